// File: rtl/permute_issue_sched_pkg.sv
// Shared types for the Permute issue scheduler: issue record, nop encoding, drain FSM states.
package permute_issue_sched_pkg;

    typedef struct packed {
        logic [0:10] op;
        logic [2:0]  format;
        logic [0:6]  rt_addr;
        logic [0:6]  ra_addr;
        logic [0:6]  rb_addr;
        logic [0:17] imm;
        logic        reg_write;
    } perm_instr_t;

    localparam logic [0:10] NOP_OP  = 11'b0;
    localparam logic [2:0]  NOP_FMT = 3'd0;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DRAINED
    } sched_state_t;

    function automatic logic is_nop(input perm_instr_t instr);
        return (instr.op == NOP_OP) && (instr.format == NOP_FMT);
    endfunction

endpackage

// File: rtl/permute_issue_sched_if.sv
// Request channel into the Permute issue scheduler: valid/ready handshake plus instruction fields.
interface permute_issue_sched_if;
    import permute_issue_sched_pkg::*;

    logic        valid;
    logic        ready;
    perm_instr_t instr;

    modport master (output valid, output instr, input ready);
    modport slave  (input valid, input instr, output ready);

endinterface

// File: rtl/permute_issue_sched_scoreboard.sv
// In-flight destination shift register with RAW match ports for one requester's ra/rb sources.
module perm_scoreboard #(
    parameter int unsigned PIPE_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_valid,
    input  logic [0:6] load_rt,
    input  logic [0:6] ra_addr,
    input  logic [0:6] rb_addr,
    output logic       ra_hit,
    output logic       ra_hit_last,
    output logic       rb_hit,
    output logic       rb_hit_last,
    output logic       empty_next
);

    // Element i holds the instruction issued i+1 edges ago; the issuing slot itself is never checked.
    logic [PIPE_DEPTH-1:0] stg_v;
    logic [0:6]            stg_rt [PIPE_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_v  <= '0;
            stg_rt <= '{default: '0};
        end else begin
            stg_v     <= {stg_v[PIPE_DEPTH-2:0], load_valid};
            stg_rt[0] <= load_rt;
            for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
                stg_rt[i] <= stg_rt[i-1];
            end
        end
    end

    // ra_hit/rb_hit cover every stage except the last; the last is reported separately for bypass.
    always_comb begin
        ra_hit = 1'b0;
        rb_hit = 1'b0;
        for (int unsigned i = 0; i < PIPE_DEPTH - 1; i++) begin
            if (stg_v[i] && (stg_rt[i] == ra_addr)) ra_hit = 1'b1;
            if (stg_v[i] && (stg_rt[i] == rb_addr)) rb_hit = 1'b1;
        end
        ra_hit_last = stg_v[PIPE_DEPTH-1] && (stg_rt[PIPE_DEPTH-1] == ra_addr);
        rb_hit_last = stg_v[PIPE_DEPTH-1] && (stg_rt[PIPE_DEPTH-1] == rb_addr);
        empty_next  = !load_valid && (stg_v[PIPE_DEPTH-2:0] == '0);
    end

endmodule

// File: rtl/permute_issue_sched.sv
// Round-robin issue scheduler for the odd-pipe Permute unit with RAW scoreboard and drain handshake.
// Optional build macro PERM_FWD_EN: last-stage hits bypass from rt_wb (fwd_ra/fwd_rb ports).
module permute_issue_sched
    import permute_issue_sched_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    permute_issue_sched_if.slave  req0,
    permute_issue_sched_if.slave  req1,
    input  logic                  drain,
    output logic                  drained,
    output logic [0:10]           op,
    output logic [2:0]            format,
    output logic [0:6]            rt_addr,
    output logic [0:17]           imm,
    output logic                  reg_write,
    output logic [0:6]            ra_addr,
`ifdef PERM_FWD_EN
    output logic                  fwd_ra,
    output logic                  fwd_rb,
`endif
    output logic [0:6]            rb_addr
);

    sched_state_t state;
    perm_instr_t  issue_q;
    perm_instr_t  sel;
    logic         rr_ptr;
    logic         accept_ok, blk0, blk1, elig0, elig1, gnt0, gnt1, accept, sb_load;
    logic         ra_hit0, ra_last0, rb_hit0, rb_last0, empty0;
    logic         ra_hit1, ra_last1, rb_hit1, rb_last1, empty1;

    perm_scoreboard #(.PIPE_DEPTH(PIPE_DEPTH)) u_sb0 (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (sb_load),
        .load_rt     (sel.rt_addr),
        .ra_addr     (req0.instr.ra_addr),
        .rb_addr     (req0.instr.rb_addr),
        .ra_hit      (ra_hit0),
        .ra_hit_last (ra_last0),
        .rb_hit      (rb_hit0),
        .rb_hit_last (rb_last0),
        .empty_next  (empty0)
    );

    perm_scoreboard #(.PIPE_DEPTH(PIPE_DEPTH)) u_sb1 (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (sb_load),
        .load_rt     (sel.rt_addr),
        .ra_addr     (req1.instr.ra_addr),
        .rb_addr     (req1.instr.rb_addr),
        .ra_hit      (ra_hit1),
        .ra_hit_last (ra_last1),
        .rb_hit      (rb_hit1),
        .rb_hit_last (rb_last1),
        .empty_next  (empty1)
    );

    always_comb begin
        accept_ok = (state == RUN) && !drain && !reset;
`ifdef PERM_FWD_EN
        blk0 = ra_hit0 | rb_hit0;
        blk1 = ra_hit1 | rb_hit1;
`else
        blk0 = ra_hit0 | ra_last0 | rb_hit0 | rb_last0;
        blk1 = ra_hit1 | ra_last1 | rb_hit1 | rb_last1;
`endif
        elig0   = req0.valid & accept_ok & ~blk0;
        elig1   = req1.valid & accept_ok & ~blk1;
        gnt0    = elig0 & (~elig1 | ~rr_ptr);
        gnt1    = elig1 & (~elig0 | rr_ptr);
        accept  = gnt0 | gnt1;
        sel     = gnt1 ? req1.instr : req0.instr;
        sb_load = accept & sel.reg_write & ~is_nop(sel);
    end

    assign req0.ready = gnt0;
    assign req1.ready = gnt1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_q <= '0;
            rr_ptr  <= 1'b0;
        end else begin
            issue_q <= accept ? sel : '0;
            if (gnt0)      rr_ptr <= 1'b1;
            else if (gnt1) rr_ptr <= 1'b0;
        end
    end

`ifdef PERM_FWD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_ra <= 1'b0;
            fwd_rb <= 1'b0;
        end else begin
            fwd_ra <= (gnt0 & ra_last0) | (gnt1 & ra_last1);
            fwd_rb <= (gnt0 & rb_last0) | (gnt1 & rb_last1);
        end
    end
`endif

    assign op        = issue_q.op;
    assign format    = issue_q.format;
    assign rt_addr   = issue_q.rt_addr;
    assign imm       = issue_q.imm;
    assign reg_write = issue_q.reg_write;
    assign ra_addr   = issue_q.ra_addr;
    assign rb_addr   = issue_q.rb_addr;

    // DRAIN looks one edge ahead so drained rises as the last entry leaves the scoreboard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            drained <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    drained <= 1'b0;
                    if (drain) state <= DRAIN;
                end
                DRAIN: begin
                    if (!drain) begin
                        state   <= RUN;
                        drained <= 1'b0;
                    end else if (empty0 && empty1) begin
                        state   <= DRAINED;
                        drained <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (!drain) begin
                        state   <= RUN;
                        drained <= 1'b0;
                    end
                end
                default: begin
                    state   <= RUN;
                    drained <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_permute_issue_sched.sv
// Self-checking bench for permute_issue_sched: directed vector table followed by randomized traffic vs. a queue-based model.
module tb_permute_issue_sched;
    import permute_issue_sched_pkg::*;

    localparam int unsigned D = 4;
`ifdef PERM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        v0;
        logic        v1;
        perm_instr_t i0;
        perm_instr_t i1;
        logic        drn;
        logic        er0;
        logic        er1;
        logic [0:10] eop;
        logic [0:6]  ert;
        logic        edrn;
    } vec_t;

    typedef struct {
        logic [0:6] rt;
        int         c;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        drain;
    logic        drained;
    logic [0:10] op;
    logic [2:0]  format;
    logic [0:6]  rt_addr, ra_addr, rb_addr;
    logic [0:17] imm;
    logic        reg_write;
`ifdef PERM_FWD_EN
    logic        fwd_ra, fwd_rb;
`endif

    permute_issue_sched_if r0 ();
    permute_issue_sched_if r1 ();

    permute_issue_sched #(.PIPE_DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (r0),
        .req1      (r1),
        .drain     (drain),
        .drained   (drained),
        .op        (op),
        .format    (format),
        .rt_addr   (rt_addr),
        .imm       (imm),
        .reg_write (reg_write),
        .ra_addr   (ra_addr),
`ifdef PERM_FWD_EN
        .fwd_ra    (fwd_ra),
        .fwd_rb    (fwd_rb),
`endif
        .rb_addr   (rb_addr)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    ent_t q[$];
    int   cyc = 0;
    logic last_g = 1'b1;
    logic prev_drn = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // 0 = free, 1 = only in its final cycle before write-back, 2 = must stall
    function automatic int src_state(input logic [0:6] a);
        int s = 0;
        foreach (q[k]) begin
            int age = cyc - q[k].c;
            if (q[k].rt == a) begin
                if (FWD ? (age < int'(D)) : (age <= int'(D))) s = 2;
                else if (age == int'(D) && s == 0) s = 1;
            end
        end
        return s;
    endfunction

    function automatic perm_instr_t mk(input logic [0:10] o, input logic [0:6] rt, ra, rb, input logic wr);
        perm_instr_t x;
        x.op = o; x.format = 3'd2; x.rt_addr = rt; x.ra_addr = ra; x.rb_addr = rb;
        x.imm = {4'hA, rt, ra}; x.reg_write = wr;
        return x;
    endfunction

    function automatic vec_t mv(input logic rst, v0, v1, input perm_instr_t i0, i1, input logic drn,
                                input logic er0, er1, input logic [0:10] eop, input logic [0:6] ert,
                                input logic edrn);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.v1 = v1; v.i0 = i0; v.i1 = i1; v.drn = drn;
        v.er0 = er0; v.er1 = er1; v.eop = eop; v.ert = ert; v.edrn = edrn;
        return v;
    endfunction

    function automatic perm_instr_t rnd_instr();
        perm_instr_t x;
        x.op        = 11'($urandom);
        x.format    = 3'($urandom_range(1, 7));
        if ($urandom_range(0, 5) == 0) begin
            x.op = '0; x.format = '0;
        end
        x.rt_addr   = 7'($urandom_range(0, 7));
        x.ra_addr   = 7'($urandom_range(0, 7));
        x.rb_addr   = 7'($urandom_range(0, 7));
        x.imm       = 18'($urandom);
        x.reg_write = ($urandom_range(0, 3) != 0);
        return x;
    endfunction

    task automatic run_cycle(input vec_t tv, input bit use_tbl, output logic a0, output logic a1);
        logic        m_r0, m_r1, m_d, m_fa, m_fb, e0, e1, acc;
        perm_instr_t m_o, ai;
        m_r0 = 1'b0; m_r1 = 1'b0; m_d = 1'b0; m_fa = 1'b0; m_fb = 1'b0;
        m_o = '0; acc = 1'b0; ai = '0;
        if (!tv.rst) begin
            e0 = tv.v0 && !prev_drn && !tv.drn &&
                 src_state(tv.i0.ra_addr) != 2 && src_state(tv.i0.rb_addr) != 2;
            e1 = tv.v1 && !prev_drn && !tv.drn &&
                 src_state(tv.i1.ra_addr) != 2 && src_state(tv.i1.rb_addr) != 2;
            if (e0 && e1) begin
                m_r0 = last_g; m_r1 = !last_g;
            end else begin
                m_r0 = e0; m_r1 = e1;
            end
            acc  = m_r0 | m_r1;
            ai   = m_r1 ? tv.i1 : tv.i0;
            m_o  = acc ? ai : '0;
            m_fa = acc && src_state(ai.ra_addr) == 1;
            m_fb = acc && src_state(ai.rb_addr) == 1;
            m_d  = tv.drn && prev_drn;
            foreach (q[k]) if (cyc - q[k].c < int'(D)) m_d = 1'b0;
        end

        reset    = tv.rst;
        drain    = tv.drn;
        r0.valid = tv.v0; r0.instr = tv.i0;
        r1.valid = tv.v1; r1.instr = tv.i1;

        @(negedge clk);
        chk("ready0", 32'(r0.ready), 32'(m_r0));
        chk("ready1", 32'(r1.ready), 32'(m_r1));
        if (use_tbl) begin
            chk("tbl_ready0", 32'(r0.ready), 32'(tv.er0));
            chk("tbl_ready1", 32'(r1.ready), 32'(tv.er1));
        end

        @(posedge clk);
        #1;
        chk("op",        32'(op),        32'(m_o.op));
        chk("format",    32'(format),    32'(m_o.format));
        chk("rt_addr",   32'(rt_addr),   32'(m_o.rt_addr));
        chk("ra_addr",   32'(ra_addr),   32'(m_o.ra_addr));
        chk("rb_addr",   32'(rb_addr),   32'(m_o.rb_addr));
        chk("imm",       32'(imm),       32'(m_o.imm));
        chk("reg_write", 32'(reg_write), 32'(m_o.reg_write));
        chk("drained",   32'(drained),   32'(m_d));
`ifdef PERM_FWD_EN
        chk("fwd_ra", 32'(fwd_ra), 32'(m_fa));
        chk("fwd_rb", 32'(fwd_rb), 32'(m_fb));
`else
        if (m_fa || m_fb) chk("fwd_model", 32'(0), 32'(1));
`endif
        if (use_tbl) begin
            chk("tbl_op",      32'(op),      32'(tv.eop));
            chk("tbl_rt",      32'(rt_addr), 32'(tv.ert));
            chk("tbl_drained", 32'(drained), 32'(tv.edrn));
        end

        if (tv.rst) begin
            q.delete();
            last_g   = 1'b1;
            prev_drn = 1'b0;
        end else begin
            if (acc && ai.reg_write && !(ai.op == '0 && ai.format == '0)) begin
                ent_t e;
                e.rt = ai.rt_addr; e.c = cyc;
                q.push_back(e);
            end
            if (acc) last_g = m_r1;
            prev_drn = tv.drn;
        end
        cyc++;
        while (q.size() > 0 && cyc - q[0].c > int'(D)) void'(q.pop_front());
        a0 = m_r0;
        a1 = m_r1;
    endtask

    initial begin
        vec_t        tbl [29];
        perm_instr_t A, B, C0, C1, NP, Dn, E, F, G, H, K, P, Q, R, Z;
        logic        a0, a1;
        logic        pv0, pv1, drn_lvl;
        perm_instr_t pi0, pi1;
        vec_t        rv;

        Z  = '0;
        A  = mk(11'b00111011100, 7'd5, 7'd1, 7'd2, 1'b1);
        B  = mk(11'h0C1, 7'd9, 7'd5, 7'd3, 1'b1);
        C0 = mk(11'h101, 7'd20, 7'd21, 7'd22, 1'b1);
        C1 = mk(11'h202, 7'd30, 7'd31, 7'd32, 1'b1);
        NP = '0; NP.rt_addr = 7'd7; NP.reg_write = 1'b1;
        Dn = mk(11'h303, 7'd7, 7'd33, 7'd34, 1'b0);
        E  = mk(11'h044, 7'd12, 7'd7, 7'd13, 1'b1);
        F  = mk(11'h1F1, 7'd40, 7'd41, 7'd42, 1'b1);
        G  = mk(11'h1F2, 7'd43, 7'd44, 7'd45, 1'b1);
        H  = mk(11'h1F3, 7'd46, 7'd47, 7'd48, 1'b1);
        K  = mk(11'h1F4, 7'd55, 7'd56, 7'd57, 1'b1);
        P  = mk(11'h1F5, 7'd50, 7'd60, 7'd61, 1'b1);
        Q  = mk(11'h1F6, 7'd51, 7'd62, 7'd63, 1'b1);
        R  = mk(11'h1F7, 7'd52, 7'd50, 7'd64, 1'b1);

        //            rst v0 v1 i0  i1  drn r0 r1 op        rt     drained
        tbl[0]  = mv(1, 1, 1, A,  B,  0, 0, 0, '0,       7'd0,  0);
        tbl[1]  = mv(0, 1, 0, A,  Z,  0, 1, 0, A.op,     7'd5,  0);
        tbl[2]  = mv(0, 0, 1, Z,  B,  0, 0, 0, '0,       7'd0,  0);
        tbl[3]  = mv(0, 0, 1, Z,  B,  0, 0, 0, '0,       7'd0,  0);
        tbl[4]  = mv(0, 0, 1, Z,  B,  0, 0, 0, '0,       7'd0,  0);
        tbl[5]  = mv(0, 0, 1, Z,  B,  0, 0, FWD, FWD ? B.op : 11'd0, FWD ? 7'd9 : 7'd0, 0);
        tbl[6]  = mv(0, 0, 1, Z,  B,  0, 0, 1, B.op,     7'd9,  0);
        tbl[7]  = mv(0, 1, 1, C0, C1, 0, 1, 0, C0.op,    7'd20, 0);
        tbl[8]  = mv(0, 1, 1, C0, C1, 0, 0, 1, C1.op,    7'd30, 0);
        tbl[9]  = mv(0, 1, 1, C0, C1, 0, 1, 0, C0.op,    7'd20, 0);
        tbl[10] = mv(0, 0, 0, C0, C1, 0, 0, 0, '0,       7'd0,  0);
        tbl[11] = mv(0, 1, 1, C0, C1, 0, 0, 1, C1.op,    7'd30, 0);
        tbl[12] = mv(0, 1, 1, NP, Dn, 0, 1, 0, '0,       7'd7,  0);
        tbl[13] = mv(0, 0, 1, Z,  Dn, 0, 0, 1, Dn.op,    7'd7,  0);
        tbl[14] = mv(0, 1, 0, E,  Z,  0, 1, 0, E.op,     7'd12, 0);
        tbl[15] = mv(0, 1, 0, F,  Z,  0, 1, 0, F.op,     7'd40, 0);
        tbl[16] = mv(0, 0, 1, Z,  G,  0, 0, 1, G.op,     7'd43, 0);
        tbl[17] = mv(0, 1, 0, H,  Z,  0, 1, 0, H.op,     7'd46, 0);
        tbl[18] = mv(0, 1, 0, K,  Z,  1, 0, 0, '0,       7'd0,  0);
        tbl[19] = mv(0, 1, 0, K,  Z,  1, 0, 0, '0,       7'd0,  0);
        tbl[20] = mv(0, 1, 0, K,  Z,  1, 0, 0, '0,       7'd0,  0);
        tbl[21] = mv(0, 1, 0, K,  Z,  1, 0, 0, '0,       7'd0,  1);
        tbl[22] = mv(0, 1, 0, K,  Z,  1, 0, 0, '0,       7'd0,  1);
        tbl[23] = mv(0, 1, 0, K,  Z,  0, 0, 0, '0,       7'd0,  0);
        tbl[24] = mv(0, 1, 0, K,  Z,  0, 1, 0, K.op,     7'd55, 0);
        tbl[25] = mv(0, 1, 0, P,  Z,  0, 1, 0, P.op,     7'd50, 0);
        tbl[26] = mv(0, 0, 1, Z,  Q,  0, 0, 1, Q.op,     7'd51, 0);
        tbl[27] = mv(1, 1, 0, R,  Z,  0, 0, 0, '0,       7'd0,  0);
        tbl[28] = mv(0, 1, 0, R,  Z,  0, 1, 0, R.op,     7'd52, 0);

        reset = 1'b1; drain = 1'b0;
        r0.valid = 1'b0; r0.instr = '0;
        r1.valid = 1'b0; r1.instr = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 29; i++) run_cycle(tbl[i], 1'b1, a0, a1);

        pv0 = 1'b0; pv1 = 1'b0; drn_lvl = 1'b0;
        pi0 = '0; pi1 = '0;
        a0 = 1'b1; a1 = 1'b1;
        for (int n = 0; n < 600; n++) begin
            if (!pv0 || a0) begin pv0 = ($urandom_range(0, 3) != 0); pi0 = rnd_instr(); end
            if (!pv1 || a1) begin pv1 = ($urandom_range(0, 3) != 0); pi1 = rnd_instr(); end
            if ($urandom_range(0, 14) == 0) drn_lvl = !drn_lvl;
            rv = mv(($urandom_range(0, 99) == 0), pv0, pv1, pi0, pi1, drn_lvl, 0, 0, '0, '0, 0);
            run_cycle(rv, 1'b0, a0, a1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
